// File: rtl/reflex_pkg.sv
// Shared definitions for the reflex game: FSM encodings and default geometry
// constants used by the hit detector, renderer and spawner.
package reflex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int DEF_COORD_W     = 10;
  localparam int DEF_TARGET_SIZE = 40;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/click_hit_detector_box_contains.sv
// Combinational point-in-square test; the right/bottom edges are formed one bit
// wider than the coordinates so targets near the screen maximum do not wrap.
import reflex_pkg::*;

module box_contains #(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int TARGET_SIZE = DEF_TARGET_SIZE
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_tx,
  input  logic [COORD_W-1:0] i_ty,
  input  logic               i_valid,
  output logic               o_inside
);

  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;

  assign w_x_end = {1'b0, i_tx} + (COORD_W+1)'(TARGET_SIZE);
  assign w_y_end = {1'b0, i_ty} + (COORD_W+1)'(TARGET_SIZE);

  assign o_inside = i_valid
                  & (i_x >= i_tx) & ({1'b0, i_x} < w_x_end)
                  & (i_y >= i_ty) & ({1'b0, i_y} < w_y_end);

endmodule

// File: rtl/click_hit_detector.sv
// Multi-target click hit detector with score/miss/streak counters and post-hit cooldown.
// Optional build macro MISS_PENALTY_EN: a miss also decrements score (saturating at 0).
//   state       | meaning
//   ST_IDLE     | game stopped, edges ignored, counters hold
//   ST_ARMED    | clicks scored as hit or miss, middle click requests respawn
//   ST_COOLDOWN | left clicks ignored until the counter expires
import reflex_pkg::*;

module click_hit_detector #(
  parameter int NUM_TARGETS = 4,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int TARGET_SIZE = DEF_TARGET_SIZE,
  parameter int SCORE_W     = 8,
  parameter int COOLDOWN    = 8,
  localparam int IDX_W      = idx_width(NUM_TARGETS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [NUM_TARGETS*COORD_W-1:0] i_target_x,
  input  logic [NUM_TARGETS*COORD_W-1:0] i_target_y,
  input  logic [NUM_TARGETS-1:0]         i_target_valid,
  input  logic [COORD_W-1:0]             i_mouse_x,
  input  logic [COORD_W-1:0]             i_mouse_y,
  input  logic                           i_mouse_left,
  input  logic                           i_mouse_middle,
  output logic [NUM_TARGETS-1:0]         o_hit_pulse,
  output logic [IDX_W-1:0]               o_hit_idx,
  output logic                           o_skip_pulse,
  output logic [SCORE_W-1:0]             o_score,
  output logic [SCORE_W-1:0]             o_miss_count,
  output logic [SCORE_W-1:0]             o_streak
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SC_ONE   = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SC_MAX   = '1;

  logic [NUM_TARGETS-1:0] w_inside;
  logic                   w_hit_any;
  logic [IDX_W-1:0]       w_hit_idx;
  logic                   w_left_edge, w_mid_edge;

  logic                   r_left_q, r_middle_q;
  logic                   r_left_edge, r_mid_edge, r_hit_any;
  logic [IDX_W-1:0]       r_hit_idx_pend;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_TARGETS-1:0] r_hit_pulse, w_hit_pulse_nxt;
  logic [IDX_W-1:0]       r_hit_idx, w_hit_idx_nxt;
  logic                   r_skip, w_skip_nxt;
  logic [SCORE_W-1:0]     r_score, w_score_nxt;
  logic [SCORE_W-1:0]     r_miss, w_miss_nxt;
  logic [SCORE_W-1:0]     r_streak, w_streak_nxt;

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_box
    box_contains #(.COORD_W(COORD_W), .TARGET_SIZE(TARGET_SIZE)) u_box (
      .i_x      (i_mouse_x),
      .i_y      (i_mouse_y),
      .i_tx     (i_target_x[g*COORD_W +: COORD_W]),
      .i_ty     (i_target_y[g*COORD_W +: COORD_W]),
      .i_valid  (i_target_valid[g]),
      .o_inside (w_inside[g])
    );
  end

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (w_inside[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_left_edge = i_mouse_left & ~r_left_q;
  assign w_mid_edge  = i_mouse_middle & ~r_middle_q;

  // Left edges arriving during cooldown are dropped here, so the window covers
  // every edge sampled up to and including the one where the counter expires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_left_q       <= 1'b0;
      r_middle_q     <= 1'b0;
      r_left_edge    <= 1'b0;
      r_mid_edge     <= 1'b0;
      r_hit_any      <= 1'b0;
      r_hit_idx_pend <= '0;
    end else begin
      r_left_q       <= i_mouse_left;
      r_middle_q     <= i_mouse_middle;
      r_left_edge    <= w_left_edge & (r_state != ST_COOLDOWN);
      r_mid_edge     <= w_mid_edge;
      r_hit_any      <= w_hit_any;
      r_hit_idx_pend <= w_hit_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hit_pulse <= '0;
      r_hit_idx   <= '0;
      r_skip      <= 1'b0;
      r_score     <= '0;
      r_miss      <= '0;
      r_streak    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hit_pulse <= w_hit_pulse_nxt;
      r_hit_idx   <= w_hit_idx_nxt;
      r_skip      <= w_skip_nxt;
      r_score     <= w_score_nxt;
      r_miss      <= w_miss_nxt;
      r_streak    <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hit_pulse_nxt = '0;
    w_hit_idx_nxt   = r_hit_idx;
    w_skip_nxt      = 1'b0;
    w_score_nxt     = r_score;
    w_miss_nxt      = r_miss;
    w_streak_nxt    = r_streak;
    if (!i_start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_ARMED;
          w_score_nxt  = '0;
          w_miss_nxt   = '0;
          w_streak_nxt = '0;
        end
        ST_ARMED: begin
          if (r_mid_edge) begin
            w_skip_nxt = 1'b1;
          end else if (r_left_edge) begin
            if (r_hit_any) begin
              w_hit_pulse_nxt[r_hit_idx_pend] = 1'b1;
              w_hit_idx_nxt = r_hit_idx_pend;
              w_score_nxt   = (r_score == SC_MAX) ? r_score : r_score + SC_ONE;
              w_streak_nxt  = (r_streak == SC_MAX) ? r_streak : r_streak + SC_ONE;
              if (COOLDOWN > 0) begin
                w_state_nxt = ST_COOLDOWN;
                w_cnt_nxt   = CNT_LOAD;
              end
            end else begin
              w_miss_nxt   = (r_miss == SC_MAX) ? r_miss : r_miss + SC_ONE;
              w_streak_nxt = '0;
`ifdef MISS_PENALTY_EN
              w_score_nxt  = (r_score == '0) ? r_score : r_score - SC_ONE;
`else
              w_score_nxt  = r_score;
`endif
            end
          end
        end
        ST_COOLDOWN: begin
          w_skip_nxt = r_mid_edge;
          if (r_cnt == '0) w_state_nxt = ST_ARMED;
          else             w_cnt_nxt   = r_cnt - CNT_ONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_hit_pulse  = r_hit_pulse;
  assign o_hit_idx    = r_hit_idx;
  assign o_skip_pulse = r_skip;
  assign o_score      = r_score;
  assign o_miss_count = r_miss;
  assign o_streak     = r_streak;

endmodule

// File: tb/tb_click_hit_detector.sv
// Directed bench for click_hit_detector: default instance (COOLDOWN=8) plus a
// SCORE_W=2, COOLDOWN=0 instance sharing the same stimulus for saturation.
module tb_click_hit_detector;

`ifdef MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, ml, mm;
  logic [39:0] tx, ty;
  logic [3:0]  tv;
  logic [9:0]  mx, my;

  logic [3:0] hp, hp2;
  logic [1:0] hi, hi2;
  logic       sp, sp2;
  logic [7:0] sc, mc, sk;
  logic [1:0] sc2, mc2, sk2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  click_hit_detector dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_target_x(tx), .i_target_y(ty), .i_target_valid(tv),
    .i_mouse_x(mx), .i_mouse_y(my), .i_mouse_left(ml), .i_mouse_middle(mm),
    .o_hit_pulse(hp), .o_hit_idx(hi), .o_skip_pulse(sp),
    .o_score(sc), .o_miss_count(mc), .o_streak(sk)
  );

  click_hit_detector #(.SCORE_W(2), .COOLDOWN(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_target_x(tx), .i_target_y(ty), .i_target_valid(tv),
    .i_mouse_x(mx), .i_mouse_y(my), .i_mouse_left(ml), .i_mouse_middle(mm),
    .o_hit_pulse(hp2), .o_hit_idx(hi2), .o_skip_pulse(sp2),
    .o_score(sc2), .o_miss_count(mc2), .o_streak(sk2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // left rise sampled on the next edge; outputs checked one edge after that
  task automatic click();
    ml = 1'b1;
    tick(1);
    ml = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ml = 1'b0; mm = 1'b0;
    tx = '0; ty = '0; tv = '0; mx = '0; my = '0;
    tick(3);
    chk("rst_hit_pulse", 32'(hp), 0);
    chk("rst_hit_idx",   32'(hi), 0);
    chk("rst_skip",      32'(sp), 0);
    chk("rst_score",     32'(sc), 0);
    chk("rst_miss",      32'(mc), 0);
    chk("rst_streak",    32'(sk), 0);

    rst = 1'b0; start = 1'b1;
    tx[0 +: 10] = 10'd100; ty[0 +: 10] = 10'd100; tv = 4'b0001;
    mx = 10'd120; my = 10'd139;
    tick(2);
    click();
    chk("hit0_pulse",  32'(hp), 32'b0001);
    chk("hit0_idx",    32'(hi), 0);
    chk("hit0_score",  32'(sc), 1);
    chk("hit0_streak", 32'(sk), 1);
    tick(1);
    chk("hit0_one_cycle", 32'(hp), 0);
    tick(12);

    mx = 10'd140; my = 10'd120;
    click();
    chk("miss_pulse",  32'(hp), 0);
    chk("miss_count",  32'(mc), 1);
    chk("miss_streak", 32'(sk), 0);
    chk("miss_score",  32'(sc), 1 - PEN);

    tv = 4'b0110;
    tx[10 +: 10] = 10'd200; ty[10 +: 10] = 10'd50;
    tx[20 +: 10] = 10'd200; ty[20 +: 10] = 10'd50;
    mx = 10'd210; my = 10'd60;
    click();
    chk("prio_pulse", 32'(hp), 32'b0010);
    chk("prio_idx",   32'(hi), 1);
    chk("prio_score", 32'(sc), 2 - PEN);

    // left rise sampled 3 edges after the hit pulse edge
    tick(2); ml = 1'b1; tick(1); ml = 1'b0; tick(1);
    chk("cd3_pulse", 32'(hp), 0);
    chk("cd3_score", 32'(sc), 2 - PEN);
    chk("cd3_miss",  32'(mc), 1);
    // sampled 8 edges after
    tick(3); ml = 1'b1; tick(1); ml = 1'b0; tick(1);
    chk("cd8_pulse", 32'(hp), 0);
    chk("cd8_score", 32'(sc), 2 - PEN);
    chk("cd8_miss",  32'(mc), 1);
    click();
    chk("cd_after_pulse", 32'(hp), 32'b0010);
    chk("cd_after_score", 32'(sc), 3 - PEN);
    // sampled 9 edges after: first scorable
    tick(8); ml = 1'b1; tick(1); ml = 1'b0; tick(1);
    chk("cd9_pulse",  32'(hp), 32'b0010);
    chk("cd9_score",  32'(sc), 4 - PEN);
    chk("cd9_streak", 32'(sk), 3);

    tick(12);
    ml = 1'b1; mm = 1'b1; tick(1); ml = 1'b0; mm = 1'b0; tick(1);
    chk("skip_pulse", 32'(sp), 1);
    chk("skip_hit",   32'(hp), 0);
    chk("skip_score", 32'(sc), 4 - PEN);
    chk("skip_miss",  32'(mc), 1);
    tick(1);
    chk("skip_one_cycle", 32'(sp), 0);

    ml = 1'b1; tick(2);
    chk("hold_pulse", 32'(hp), 32'b0010);
    tick(20);
    chk("hold_score",  32'(sc), 5 - PEN);
    chk("hold_streak", 32'(sk), 4);
    ml = 1'b0;

    tv = 4'b1000;
    tx[30 +: 10] = 10'd1000; ty[30 +: 10] = 10'd1000;
    mx = 10'd1020; my = 10'd1020;
    tick(2);
    click();
    chk("edge_pulse", 32'(hp), 32'b1000);
    chk("edge_idx",   32'(hi), 3);
    chk("edge_score", 32'(sc), 6 - PEN);

    tick(2);
    rst = 1'b1; tick(1);
    chk("rstcd_pulse",  32'(hp), 0);
    chk("rstcd_idx",    32'(hi), 0);
    chk("rstcd_score",  32'(sc), 0);
    chk("rstcd_miss",   32'(mc), 0);
    chk("rstcd_streak", 32'(sk), 0);
    rst = 1'b0;

    tick(1);
    click();
    chk("rehit_score", 32'(sc), 1);
    tick(12);
    start = 1'b0; tick(2);
    chk("stop_hold_score", 32'(sc), 1);
    start = 1'b1; tick(2);
    chk("restart_score",  32'(sc), 0);
    chk("restart_streak", 32'(sk), 0);

    mx = 10'd0; my = 10'd0;
    click();
    chk("miss0_count", 32'(mc), 1);
    chk("miss0_score", 32'(sc), 0);

    mx = 10'd1020; my = 10'd1020;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      ml = 1'b1; tick(1);
      ml = 1'b0; tick(1);
    end
    chk("sat_score",  32'(sc2), 3);
    chk("sat_streak", 32'(sk2), 3);
    chk("sat_miss",   32'(mc2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
